// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and control types for the MEM/WB stage. Optional WB_RETIRE_CNT_EN adds a retire counter in the top.
`ifndef WORD
`define WORD 32
`endif
`ifndef RA_W
`define RA_W 5
`endif

package mem_wb_stage_pkg;

    localparam int WORD_W     = `WORD;
    localparam int REG_ADDR_W = `RA_W;
    localparam int CNT_W      = 32;

    // Control bits that survive into the write-back stage
    typedef struct packed {
        logic vld;
        logic reg_w;
    } wb_ctl_t;

endpackage

// File: rtl/mem_wb_stage_hist.sv
// wb_hist_reg: one-entry record of the last committed register-file write, with hold.
module wb_hist_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int WORD = WORD_W,
    parameter int RA_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            d_valid,
    input  logic [RA_W-1:0] d_addr,
    input  logic [WORD-1:0] d_data,
    output logic            q_valid,
    output logic [RA_W-1:0] q_addr,
    output logic [WORD-1:0] q_data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_addr  <= '0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_addr  <= d_addr;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back select and forwarding sources.
// Optional macro WB_RETIRE_CNT_EN adds a 32-bit retire_cnt output.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int WORD = WORD_W,
    parameter int RA_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_reg_w,
    input  logic            in_mem_to_reg,
    input  logic [RA_W-1:0] in_dest,
    input  logic [WORD-1:0] in_mem_data,
    input  logic [WORD-1:0] in_alu_data,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_addr,
    output logic [WORD-1:0] wb_data,
    output logic            fwd0_valid,
    output logic [RA_W-1:0] fwd0_addr,
    output logic [WORD-1:0] fwd0_data,
    output logic            fwd1_valid,
    output logic [RA_W-1:0] fwd1_addr,
    output logic [WORD-1:0] fwd1_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    function automatic logic [WORD-1:0] select_wb(input logic       mem_to_reg,
                                                  input logic [WORD-1:0] mem_data,
                                                  input logic [WORD-1:0] alu_data);
        return mem_to_reg ? mem_data : alu_data;
    endfunction

    function automatic logic commits(input wb_ctl_t ctl, input logic [RA_W-1:0] dest);
        return ctl.vld & ctl.reg_w & (dest != '0);
    endfunction

    wb_ctl_t         ctl_p0;
    logic [RA_W-1:0] dest_p0;
    logic [WORD-1:0] data_p0;
    logic            commit_p0;

    // Stage p0: MEM/WB register; the data mux is resolved before capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_p0  <= '0;
            dest_p0 <= '0;
            data_p0 <= '0;
        end else if (flush) begin
            ctl_p0  <= '0;
            dest_p0 <= '0;
            data_p0 <= '0;
        end else if (!stall) begin
            ctl_p0.vld   <= in_valid;
            ctl_p0.reg_w <= in_reg_w;
            dest_p0      <= in_dest;
            data_p0      <= select_wb(in_mem_to_reg, in_mem_data, in_alu_data);
        end
    end

    assign commit_p0  = commits(ctl_p0, dest_p0);
    assign wb_we      = commit_p0 & ~stall;
    assign wb_addr    = dest_p0;
    assign wb_data    = data_p0;
    assign fwd0_valid = commit_p0;
    assign fwd0_addr  = dest_p0;
    assign fwd0_data  = data_p0;

    // A flush retires the outgoing entry into history even while stalled
    wb_hist_reg #(
        .WORD (WORD),
        .RA_W (RA_W)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .en      (~stall | flush),
        .d_valid (commit_p0),
        .d_addr  (dest_p0),
        .d_data  (data_p0),
        .q_valid (fwd1_valid),
        .q_addr  (fwd1_addr),
        .q_data  (fwd1_data)
    );

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else if (!stall && ctl_p0.vld) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected outputs, negedge monitor pops and compares.
module tb_mem_wb_stage;

    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0, flush = 1'b0;
    logic         in_valid = 1'b0, in_reg_w = 1'b0, in_mem_to_reg = 1'b0;
    logic [A-1:0] in_dest = '0;
    logic [W-1:0] in_mem_data = '0, in_alu_data = '0;
    logic         wb_we, fwd0_valid, fwd1_valid;
    logic [A-1:0] wb_addr, fwd0_addr, fwd1_addr;
    logic [W-1:0] wb_data, fwd0_data, fwd1_data;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]  retire_cnt;
`endif

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_w      (in_reg_w),
        .in_mem_to_reg (in_mem_to_reg),
        .in_dest       (in_dest),
        .in_mem_data   (in_mem_data),
        .in_alu_data   (in_alu_data),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .fwd0_valid    (fwd0_valid),
        .fwd0_addr     (fwd0_addr),
        .fwd0_data     (fwd0_data),
        .fwd1_valid    (fwd1_valid),
        .fwd1_addr     (fwd1_addr),
        .fwd1_data     (fwd1_data)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         stall, flush, v, rw, m2r;
        logic [A-1:0] dest;
        logic [W-1:0] mem, alu;
    } stim_t;

    typedef struct {
        logic         we, f0v, f1v;
        logic [A-1:0] addr, f1a;
        logic [W-1:0] data, f1d, cnt;
    } exp_t;

    exp_t  exp_q[$];
    stim_t cur;
    int    errors = 0;
    int    checks = 0;

    // Reference: the entry waiting to commit, the last committed write, and the retire tally
    logic         m_vld, m_rw;
    logic [A-1:0] m_dest;
    logic [W-1:0] m_val;
    logic         h_vld;
    logic [A-1:0] h_addr;
    logic [W-1:0] h_val;
    logic [W-1:0] m_cnt;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic s, input logic f, input logic v, input logic rw,
                                 input logic m2r, input logic [A-1:0] d,
                                 input logic [W-1:0] mem, input logic [W-1:0] alu);
        stim_t r;
        r.stall = s; r.flush = f; r.v = v; r.rw = rw; r.m2r = m2r;
        r.dest = d; r.mem = mem; r.alu = alu;
        return r;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_rw = 0; m_dest = '0; m_val = '0;
        h_vld = 0; h_addr = '0; h_val = '0; m_cnt = '0;
    endtask

    task automatic model_edge(input stim_t s);
        logic wrote;
        wrote = m_vld && m_rw && (m_dest != 0);
        if (!s.stall && m_vld) m_cnt = m_cnt + 1;
        if (s.flush || !s.stall) begin
            h_vld = wrote;
            if (wrote) begin
                h_addr = m_dest;
                h_val  = m_val;
            end
        end
        if (s.flush) begin
            m_vld = 0;
            m_rw  = 0;
        end else if (!s.stall) begin
            m_vld  = s.v;
            m_rw   = s.rw;
            m_dest = s.dest;
            m_val  = s.m2r ? s.mem : s.alu;
        end
    endtask

    task automatic apply(input stim_t s);
        stall = s.stall; flush = s.flush; in_valid = s.v; in_reg_w = s.rw;
        in_mem_to_reg = s.m2r; in_dest = s.dest; in_mem_data = s.mem; in_alu_data = s.alu;
    endtask

    task automatic cycle(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge(cur);
        cur = s;
        apply(s);
        e.f0v  = m_vld && m_rw && (m_dest != 0);
        e.we   = e.f0v && !s.stall;
        e.addr = m_dest;
        e.data = m_val;
        e.f1v  = h_vld;
        e.f1a  = h_addr;
        e.f1d  = h_val;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            chk("fwd0_valid", {31'd0, fwd0_valid}, {31'd0, e.f0v});
            chk("fwd1_valid", {31'd0, fwd1_valid}, {31'd0, e.f1v});
            if (e.f0v) begin
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                chk("wb_data", wb_data, e.data);
                chk("fwd0_addr", {27'd0, fwd0_addr}, {27'd0, e.addr});
                chk("fwd0_data", fwd0_data, e.data);
            end
            if (e.f1v) begin
                chk("fwd1_addr", {27'd0, fwd1_addr}, {27'd0, e.f1a});
                chk("fwd1_data", fwd1_data, e.f1d);
            end
`ifdef WB_RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt, e.cnt);
`endif
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, {31'd0, wb_we}, 32'd0);
        chk({tag, "_addr"}, {27'd0, wb_addr}, 32'd0);
        chk({tag, "_data"}, wb_data, 32'd0);
        chk({tag, "_f0v"}, {31'd0, fwd0_valid}, 32'd0);
        chk({tag, "_f0d"}, fwd0_data, 32'd0);
        chk({tag, "_f1v"}, {31'd0, fwd1_valid}, 32'd0);
        chk({tag, "_f1a"}, {27'd0, fwd1_addr}, 32'd0);
        chk({tag, "_f1d"}, fwd1_data, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cur = idle();
        apply(cur);
        #23;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU write, then load, then r0 target
        cycle(mk(0, 0, 1, 1, 0, 5, 32'h0BAD_0BAD, 32'h1234));
        cycle(mk(0, 0, 1, 1, 1, 7, 32'hDEADBEEF, 32'h40));
        cycle(mk(0, 0, 1, 1, 0, 0, 32'h0, 32'h5555));
        cycle(idle());
        cycle(idle());
        cycle(idle());

        // Stall holds a pending write for three cycles
        cycle(mk(0, 0, 1, 1, 0, 3, 32'h0, 32'h33));
        repeat (3) cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
        cycle(idle());
        cycle(idle());

        // Flush together with stall: the outgoing write still lands in history
        cycle(mk(0, 0, 1, 1, 0, 10, 32'h0, 32'hAA));
        cycle(mk(0, 0, 1, 1, 0, 11, 32'h0, 32'hBB));
        cycle(mk(1, 1, 1, 1, 0, 12, 32'h0, 32'hCC));
        cycle(idle());
        cycle(idle());

        // Back-to-back writes to one register
        cycle(mk(0, 0, 1, 1, 0, 4, 32'h0, 32'h111));
        cycle(mk(0, 0, 1, 1, 1, 4, 32'h222, 32'h0));
        cycle(idle());
        cycle(idle());

        for (int i = 0; i < 300; i++) begin
            cycle(mk($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom));
        end

        // Asynchronous reset while a write is on the port
        cycle(mk(0, 0, 1, 1, 0, 9, 32'h0, 32'h99));
        cycle(idle());
        @(negedge clk);
        #2;
        chk("pre_rst_we", {31'd0, wb_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(idle());
        cycle(idle());

`ifdef WB_RETIRE_CNT_EN
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 8) cycle(idle());
            else cycle(mk(0, 0, 1, (i % 3) != 0, 0, 5'(i), 32'h0, 32'(i)));
        end
        cycle(idle());
        cycle(idle());
        @(negedge clk);
        #2;
        chk("retire_10", retire_cnt, 32'd10);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        cycle(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0));
        cycle(idle());
        cycle(idle());
        @(negedge clk);
        #2;
        chk("retire_wrap", retire_cnt, 32'd0);
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select. Sits directly downstream of the memory stage.
- Captures the memory stage's load data, ALU pass-through and control, then drives the register-file write port.
- Drives two forwarding sources for the EX-stage bypass mux:
  - the current write-back result;
  - a one-entry history of the previous committed write, covering register files without internal write-through.

Parameters:
- WORD, `WORD (32), datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  hold all state this cycle.
- flush  in  1  squash the incoming entry.
- in_valid  in  1  memory-stage entry is valid.
- in_reg_w  in  1  entry writes the register file.
- in_mem_to_reg  in  1  1 = select load data, 0 = select ALU result.
- in_dest  in  RA_W  destination register.
- in_mem_data  in  WORD  load data from the memory stage.
- in_alu_data  in  WORD  ALU result from the memory stage.
- wb_we  out  1  register-file write enable.
- wb_addr  out  RA_W  register-file write address.
- wb_data  out  WORD  register-file write data.
- fwd0_valid / fwd0_addr / fwd0_data  out  1/RA_W/WORD  forwarding from the current write-back.
- fwd1_valid / fwd1_addr / fwd1_data  out  1/RA_W/WORD  forwarding from the previous committed write.

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared.
  - wb_we=0, wb_addr=0, wb_data=0.
  - fwd0_* = 0, fwd1_* = 0.
  - Reset asserted mid-stream drops any in-flight entry; no write is produced.
- Latch rule, evaluated each rising edge, in priority order:
  - flush=1 (even if stall=1): stage register becomes a bubble (valid=0, reg_w=0). History is still updated from the outgoing entry.
  - stall=1: stage register and history both hold. wb_we stays deasserted while stalled, so a write is never committed twice.
  - otherwise: the stage register loads the in_* fields.
- Latency: exactly 1 cycle from in_* to wb_*.
- Select: the data mux is evaluated at capture time and one WORD is stored.
  - in_mem_to_reg=1 stores in_mem_data; 0 stores in_alu_data.
  - in_mem_data is not used when in_mem_to_reg=0.
- Write enable: wb_we = valid & reg_w & (addr != 0) & !stall. Register 0 is never written.
- fwd0:
  - fwd0_valid = valid & reg_w & (addr != 0), independent of stall.
  - fwd0_addr = wb_addr, fwd0_data = wb_data.
- History register (fwd1):
  - On each non-stalled edge where wb_we was 1, history <= {1, wb_addr, wb_data}.
  - On a non-stalled edge with no write, history valid <= 0.
  - Net effect: fwd1 always reflects the write committed exactly one cycle earlier.
- Priority when addresses match: the consumer must prefer fwd0 over fwd1. This stage does not merge them.
- Back-to-back writes to the same register: fwd0 carries the new value and fwd1 the old value. Both are valid at once.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt, 32 bits.
  - Increments on every non-stalled edge where the stage register holds valid=1, counting bubbles as not retired. Includes entries with reg_w=0 such as stores.
  - Wraps from 0xFFFFFFFF to 0. Reset to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Shared constants include file: `WORD and a new `RA_W define, plus any control-bundle field widths.
- One natural sub-module, wb_hist_reg: the one-entry history register with hold.
- The stage register and select stay inline.

Test Plan:
- Reset release, then in_valid=1, reg_w=1, dest=5, mem_to_reg=0, alu=0x1234 → next cycle wb_we=1, wb_addr=5, wb_data=0x1234, fwd0_valid=1.
- Load: mem_to_reg=1, mem=0xDEADBEEF, alu=0x40, dest=7 → wb_data=0xDEADBEEF. One cycle later fwd1 = {1, 7, 0xDEADBEEF}.
- dest=0, reg_w=1 → wb_we=0, fwd0_valid=0, history valid=0 on the next cycle.
- Write to r3 latched, then stall=1 for 3 cycles → wb_we=0 during the stall, fwd0 is held valid, wb_we rises exactly once after release, and fwd1 is unchanged during the stall.
- flush=1 together with stall=1 and a valid entry → next cycle wb_we=0 and fwd0_valid=0; the history captures the previous write.
- rst pulsed low mid-cycle while wb_we=1 → outputs drop to 0 immediately, without waiting for a clock edge.
- With WB_RETIRE_CNT_EN defined: 10 valid entries with 2 bubbles interleaved → retire_cnt=10. Preloading 0xFFFFFFFF via force and sending one valid entry gives 0.
